// File: rtl/el_cmd_tx_if.sv
// ---------------------------------------------------------------------------
// el_cmd_tx_if -- command handshake between a text producer and el_cmd_tx.
//
// Signals:
//   in_cmd_valid   producer -> tx   command request
//   out_cmd_ready  tx -> producer   command acceptance (transfer on valid&ready)
//   in_cmd_op      producer -> tx   00 put char, 01 goto+put, 10 clear, 11 newline
//   in_cmd_char    producer -> tx   character code for ops 00/01
//   in_cmd_col     producer -> tx   target column for op 01 (0..39)
//   in_cmd_row     producer -> tx   target row for op 01 (0..31)
//   out_cmd_error  tx -> producer   one-cycle pulse on a rejected command
//
// Modports: master (command producer), slave (el_cmd_tx).
// ---------------------------------------------------------------------------
interface el_cmd_tx_if;
  logic       in_cmd_valid;
  logic       out_cmd_ready;
  logic [1:0] in_cmd_op;
  logic [6:0] in_cmd_char;
  logic [5:0] in_cmd_col;
  logic [4:0] in_cmd_row;
  logic       out_cmd_error;

  modport master (
    output in_cmd_valid, in_cmd_op, in_cmd_char, in_cmd_col, in_cmd_row,
    input  out_cmd_ready, out_cmd_error
  );

  modport slave (
    input  in_cmd_valid, in_cmd_op, in_cmd_char, in_cmd_col, in_cmd_row,
    output out_cmd_ready, out_cmd_error
  );
endinterface

// File: rtl/el_cmd_tx.sv
// ---------------------------------------------------------------------------
// el_cmd_tx -- turns text-display commands into 8N1 UART bytes for an
// external display controller.
//
// Parameters:
//   CLKS_PER_BIT  main-clock cycles per UART bit (<= 1023)
//   CLEAR_GUARD   idle cycles enforced after a clear byte (<= 65535)
//
// Ports:
//   in_main_clock  sole clock, rising edge
//   in_reset_n     asynchronous active-low reset
//   cmd            el_cmd_tx_if.slave command handshake
//   out_uart_tx    serial line, idle high
//
// Build option: define EL_CMD_TX_CURSOR_SKIP_EN to drop goto column/row
// bytes that the shadow cursor shows are already in effect.
// ---------------------------------------------------------------------------
module el_cmd_tx #(
  parameter int CLKS_PER_BIT = 231,
  parameter int CLEAR_GUARD  = 4096
) (
  input  logic       in_main_clock,
  input  logic       in_reset_n,
  el_cmd_tx_if.slave cmd,
  output logic       out_uart_tx
);

  typedef enum logic [1:0] {OP_PUT, OP_GOTO, OP_CLEAR, OP_NL} op_e;

  // LOAD (encode + validate) is evaluated combinationally and committed on the
  // accepting edge or the last stop-bit edge, so it costs no cycle: this keeps
  // the one-cycle start latency and back-to-back bytes.
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GUARD} state_e;

  localparam logic [9:0]  BIT_LAST   = 10'(CLKS_PER_BIT - 1);
  localparam logic [15:0] GUARD_LAST = 16'(CLEAR_GUARD - 1);

  state_e      r_state;
  logic        r_tx, r_ready, r_err;
  logic [7:0]  r_byte, r_pend0, r_pend1;
  logic [1:0]  r_pend_cnt;
  logic [9:0]  r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic [15:0] r_guard_cnt;
  logic [5:0]  r_cur_col;
  logic [4:0]  r_cur_row;
  logic        r_cur_valid;

  op_e         w_op;
  logic        w_char_bad, w_reject, w_col_en, w_row_en, w_put;
  logic [7:0]  w_seq0, w_seq1, w_seq2, w_char_byte, w_col_byte, w_row_byte;
  logic [1:0]  w_len;
  logic [5:0]  w_base_col, w_nxt_col;
  logic [4:0]  w_base_row, w_nxt_row;
  logic        w_nxt_valid;

  assign w_op = op_e'(cmd.in_cmd_op);

  // Encode the incoming command into up to three bytes and compute where the
  // controller's cursor will be once it has been processed.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    w_char_byte = {1'b0, cmd.in_cmd_char};
    w_col_byte  = 8'h80 | {2'b00, cmd.in_cmd_col};
    w_row_byte  = 8'hC0 | {3'b000, cmd.in_cmd_row};
    w_char_bad  = (cmd.in_cmd_char == 7'h0A) || (cmd.in_cmd_char == 7'h0D);
    w_reject    = 1'b0;
    w_col_en    = 1'b1;
    w_row_en    = 1'b1;
`ifdef EL_CMD_TX_CURSOR_SKIP_EN
    if (r_cur_valid && (r_cur_col == cmd.in_cmd_col)) w_col_en = 1'b0;
    if (r_cur_valid && (r_cur_row == cmd.in_cmd_row)) w_row_en = 1'b0;
`endif
    w_seq0      = w_char_byte;
    w_seq1      = w_char_byte;
    w_seq2      = w_char_byte;
    w_len       = 2'd1;
    w_base_col  = r_cur_col;
    w_base_row  = r_cur_row;
    w_nxt_col   = r_cur_col;
    w_nxt_row   = r_cur_row;
    w_nxt_valid = r_cur_valid;
    w_put       = 1'b0;

    case (w_op)
      OP_PUT: begin
        w_reject = w_char_bad;
        w_put    = 1'b1;
      end
      OP_GOTO: begin
        // A 5-bit row can never exceed 31, so only the column is range checked.
        w_reject    = w_char_bad || (cmd.in_cmd_col > 6'd39);
        w_base_col  = cmd.in_cmd_col;
        w_base_row  = cmd.in_cmd_row;
        w_nxt_valid = 1'b1;
        w_put       = 1'b1;
        case ({w_col_en, w_row_en})
          2'b11:   begin w_seq0 = w_col_byte; w_seq1 = w_row_byte; w_len = 2'd3; end
          2'b10:   begin w_seq0 = w_col_byte; w_len = 2'd2; end
          2'b01:   begin w_seq0 = w_row_byte; w_len = 2'd2; end
          default: w_len = 2'd1;
        endcase
      end
      OP_CLEAR: begin
        w_seq0      = 8'hFF;
        w_nxt_col   = 6'd0;
        w_nxt_row   = 5'd0;
        w_nxt_valid = 1'b1;
      end
      default: begin  // newline; row wraps 31 -> 0 through 5-bit overflow
        w_seq0    = 8'h0A;
        w_nxt_col = 6'd0;
        w_nxt_row = r_cur_row + 5'd1;
      end
    endcase

    // A printed character advances the cursor, wrapping at column 40.
    if (w_put) begin
      if (w_base_col == 6'd39) begin
        w_nxt_col = 6'd0;
        w_nxt_row = w_base_row + 5'd1;
      end else begin
        w_nxt_col = w_base_col + 6'd1;
        w_nxt_row = w_base_row;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge in_main_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b1;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_byte      <= 8'h00;
      r_pend0     <= 8'h00;
      r_pend1     <= 8'h00;
      r_pend_cnt  <= 2'd0;
      r_bit_cnt   <= 10'd0;
      r_bit_idx   <= 3'd0;
      r_guard_cnt <= 16'd0;
      r_cur_col   <= 6'd0;
      r_cur_row   <= 5'd0;
      r_cur_valid <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (cmd.in_cmd_valid) begin
            if (w_reject) begin
              // Ready simply stays high; the producer may retry at once.
              r_err <= 1'b1;
            end else begin
              r_ready     <= 1'b0;
              r_tx        <= 1'b0;
              r_state     <= S_START;
              r_bit_cnt   <= 10'd0;
              r_byte      <= w_seq0;
              r_pend0     <= w_seq1;
              r_pend1     <= w_seq2;
              r_pend_cnt  <= w_len - 2'd1;
              r_cur_col   <= w_nxt_col;
              r_cur_row   <= w_nxt_row;
              r_cur_valid <= w_nxt_valid;
            end
          end
        end
        S_START: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= 10'd0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_byte[0];
            r_state   <= S_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 10'd1;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= 10'd0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 10'd1;
          end
        end
        S_STOP: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= 10'd0;
            if (r_pend_cnt != 2'd0) begin
              r_byte     <= r_pend0;
              r_pend0    <= r_pend1;
              r_pend_cnt <= r_pend_cnt - 2'd1;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else if ((r_byte == 8'hFF) && (CLEAR_GUARD > 0)) begin
              // The controller needs quiet time to wipe its screen buffer.
              r_guard_cnt <= 16'd0;
              r_state     <= S_GUARD;
            end else begin
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 10'd1;
          end
        end
        S_GUARD: begin
          if (r_guard_cnt == GUARD_LAST) begin
            r_guard_cnt <= 16'd0;
            r_ready     <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt + 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_uart_tx       = r_tx;
  assign cmd.out_cmd_ready = r_ready;
  assign cmd.out_cmd_error = r_err;

endmodule

// File: tb/tb_el_cmd_tx.sv
// ---------------------------------------------------------------------------
// tb_el_cmd_tx -- self-checking bench for el_cmd_tx (CLKS_PER_BIT=4,
// CLEAR_GUARD=16). A reference model turns each command into the expected
// byte list and cursor update; the line is compared bit-slot by bit-slot,
// together with ready/error timing. Directed cases first, then random ones.
// ---------------------------------------------------------------------------
module tb_el_cmd_tx;
  localparam int CPB = 4;
  localparam int CG  = 16;
`ifdef EL_CMD_TX_CURSOR_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;

  el_cmd_tx_if cmd_if();

  el_cmd_tx #(.CLKS_PER_BIT(CPB), .CLEAR_GUARD(CG)) dut (
    .in_main_clock (clk),
    .in_reset_n    (rst_n),
    .cmd           (cmd_if),
    .out_uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference cursor of the display controller.
  int m_col = 0;
  int m_row = 0;
  bit m_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_advance();
    m_col = m_col + 1;
    if (m_col == 40) begin
      m_col = 0;
      m_row = (m_row + 1) % 32;
    end
  endfunction

  // Fills exp_q with the bytes the controller must receive; rej=1 if refused.
  function automatic void model_cmd(input int op, input int ch, input int col,
                                    input int row, output bit rej);
    exp_q.delete();
    rej = 1'b0;
    case (op)
      0: begin
        if (ch == 'h0A || ch == 'h0D) rej = 1'b1;
        else begin
          exp_q.push_back(8'(ch));
          model_advance();
        end
      end
      1: begin
        if (ch == 'h0A || ch == 'h0D || col > 39) rej = 1'b1;
        else begin
          if (!(SKIP && m_valid && m_col == col)) exp_q.push_back(8'(128 + col));
          if (!(SKIP && m_valid && m_row == row)) exp_q.push_back(8'(192 + row));
          exp_q.push_back(8'(ch));
          m_col = col;
          m_row = row;
          m_valid = 1'b1;
          model_advance();
        end
      end
      2: begin
        exp_q.push_back(8'hFF);
        m_col = 0;
        m_row = 0;
        m_valid = 1'b1;
      end
      default: begin
        exp_q.push_back(8'h0A);
        m_col = 0;
        m_row = (m_row + 1) % 32;
      end
    endcase
  endfunction

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_if.out_cmd_ready === 1'b1) return;
      @(negedge clk);
    end
    check("ready_timeout", cmd_if.out_cmd_ready, 1);
  endtask

  task automatic drive(input int op, input int ch, input int col, input int row);
    cmd_if.in_cmd_valid = 1'b1;
    cmd_if.in_cmd_op    = 2'(op);
    cmd_if.in_cmd_char  = 7'(ch);
    cmd_if.in_cmd_col   = 6'(col);
    cmd_if.in_cmd_row   = 5'(row);
  endtask

  // Issues one command and checks the whole resulting line activity.
  // Valid is kept asserted with scrambled fields while busy; none of that
  // may be taken as a new command.
  task automatic run_cmd(input string tag, input int op, input int ch, input int col, input int row);
    bit rej;
    logic [CPB-1:0] slot;
    logic [CG-1:0] g_tx, g_rdy;
    logic busy_rdy, busy_err, eb;
    wait_ready(300);
    model_cmd(op, ch, col, row, rej);
    drive(op, ch, col, row);
    @(posedge clk);
    #1;
    if (rej) begin
      cmd_if.in_cmd_valid = 1'b0;
      @(negedge clk);
      check({tag, "/err_pulse"}, cmd_if.out_cmd_error, 1);
      check({tag, "/rej_ready"}, cmd_if.out_cmd_ready, 1);
      check({tag, "/rej_line"}, uart_tx, 1);
      @(negedge clk);
      check({tag, "/err_end"}, cmd_if.out_cmd_error, 0);
      for (int k = 0; k < CPB; k++) begin
        slot[k] = uart_tx;
        @(negedge clk);
      end
      check({tag, "/rej_quiet"}, slot, {CPB{1'b1}});
    end else begin
      drive($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 31));
      busy_rdy = 1'b0;
      busy_err = 1'b0;
      foreach (exp_q[b]) begin
        for (int bi = 0; bi < 10; bi++) begin
          eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : exp_q[b][bi-1];
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            slot[k]  = uart_tx;
            busy_rdy = busy_rdy | cmd_if.out_cmd_ready;
            busy_err = busy_err | cmd_if.out_cmd_error;
          end
          check($sformatf("%s/byte%0d_%02h/bit%0d", tag, b, exp_q[b], bi), slot, {CPB{eb}});
        end
      end
      check({tag, "/busy_ready"}, busy_rdy, 0);
      check({tag, "/busy_err"}, busy_err, 0);
      if (exp_q[exp_q.size()-1] == 8'hFF) begin
        for (int k = 0; k < CG; k++) begin
          @(negedge clk);
          g_tx[k]  = uart_tx;
          g_rdy[k] = cmd_if.out_cmd_ready;
        end
        check({tag, "/guard_line"}, g_tx, {CG{1'b1}});
        check({tag, "/guard_ready"}, g_rdy, 0);
      end
      @(negedge clk);
      check({tag, "/ready_back"}, cmd_if.out_cmd_ready, 1);
      check({tag, "/idle_line"}, uart_tx, 1);
      cmd_if.in_cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int op, ch, col, row;
    cmd_if.in_cmd_valid = 1'b0;
    cmd_if.in_cmd_op    = 2'd0;
    cmd_if.in_cmd_char  = 7'd0;
    cmd_if.in_cmd_col   = 6'd0;
    cmd_if.in_cmd_row   = 5'd0;

    // Reset state and release.
    repeat (3) @(negedge clk);
    check("rst/line", uart_tx, 1);
    check("rst/ready", cmd_if.out_cmd_ready, 0);
    check("rst/err", cmd_if.out_cmd_error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready_first_clk", cmd_if.out_cmd_ready, 1);

    // Directed cases.
    run_cmd("put_A", 0, 'h41, 0, 0);
    run_cmd("goto_5_3_B", 1, 'h42, 5, 3);
    run_cmd("goto_6_3_C", 1, 'h43, 6, 3);
    run_cmd("clear", 2, 0, 0, 0);
    run_cmd("rej_col40", 1, 'h41, 40, 0);
    run_cmd("rej_put_0D", 0, 'h0D, 0, 0);
    run_cmd("rej_goto_0A", 1, 'h0A, 1, 1);
    run_cmd("newline", 3, 0, 0, 0);
    run_cmd("goto_39_31", 1, 'h5A, 39, 31);
    run_cmd("put_wrap", 0, 'h21, 0, 0);

    // Random commands, biased towards repeating the current cursor.
    for (int n = 0; n < 40; n++) begin
      op  = $urandom_range(0, 3);
      ch  = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 'h0A : 'h0D)
                                        : $urandom_range(0, 127);
      col = $urandom_range(0, 47);
      row = $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) col = m_col;
      if ($urandom_range(0, 2) == 0) row = m_row;
      run_cmd($sformatf("rnd%0d_op%0d", n, op), op, ch, col, row);
    end

    // Reset in the middle of data bit 2 of byte 0xC3.
    wait_ready(300);
    drive(1, 'h42, 5, 3);
    @(posedge clk);
    #1;
    cmd_if.in_cmd_valid = 1'b0;
    repeat (55) @(negedge clk);
    check("midrst/line_low_before", uart_tx, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst/line", uart_tx, 1);
    check("midrst/ready", cmd_if.out_cmd_ready, 0);
    check("midrst/err", cmd_if.out_cmd_error, 0);
    m_col = 0;
    m_row = 0;
    m_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/line_held", uart_tx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst/ready_first_clk", cmd_if.out_cmd_ready, 1);
    run_cmd("post_rst_put_A", 0, 'h41, 0, 0);
    run_cmd("post_rst_goto", 1, 'h44, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/el_cmd_tx.md
EL_CMD_TX -- requirements
Module: el_cmd_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 231, giving main-clock cycles per UART bit (230400 baud at 53.20 MHz).
REQ-002 SHALL have parameter CLEAR_GUARD, default 4096, giving idle cycles enforced after a clear byte.
REQ-003 in_main_clock  input  1  sole clock; all logic on rising edge.
REQ-004 in_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_cmd_valid  input  1  command request.
REQ-006 out_cmd_ready  output  1  command acceptance; a command transfers when in_cmd_valid and out_cmd_ready are both high.
REQ-007 in_cmd_op  input  2  00 put char, 01 goto+put char, 10 clear screen, 11 newline.
REQ-008 in_cmd_char  input  7  character code for ops 00/01.
REQ-009 in_cmd_col  input  6  target column for op 01, legal 0..39.
REQ-010 in_cmd_row  input  5  target row for op 01, legal 0..31.
REQ-011 out_uart_tx  output  1  8N1 serial line to the display controller.
REQ-012 out_cmd_error  output  1  one-cycle pulse on a rejected command.

Function
REQ-013 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles; idle line high.
REQ-014 SHALL encode: op 00 -> {0,char}; op 01 -> 0x80|col, 0xC0|row, {0,char}, in that order; op 10 -> 0xFF; op 11 -> 0x0A.
REQ-015 SHALL transmit bytes of one command back-to-back, next start bit in the cycle after the previous stop bit ends.
REQ-016 SHALL drop out_cmd_ready the cycle after acceptance; the first start bit begins that same cycle (latency 1).
REQ-017 SHALL reassert out_cmd_ready the cycle after the last stop bit ends, except after op 10, where it reasserts only after a further CLEAR_GUARD cycles with the line high.
REQ-018 SHALL reject ops 00/01 with char 0x0A or 0x0D, and op 01 with col>39 or row>31: no line activity, out_cmd_error high for the cycle after acceptance, out_cmd_ready high again that same cycle.
REQ-019 SHALL ignore command inputs while out_cmd_ready is low.
REQ-020 State machine: IDLE -> LOAD (encode, validate) -> START -> DATA (8 bits) -> STOP -> LOAD-next-byte or GUARD (after 0xFF) or IDLE; LOAD -> IDLE on reject.
REQ-021 SHALL maintain a shadow cursor (col 6b, row 5b, valid flag) mirroring the controller: put char col+1, col 40 -> col 0 with row+1; row 32 -> 0; newline col 0, row+1 with wrap; clear (0,0) valid; goto sets target and marks valid.
REQ-022 Bit-period counter SHALL be wide enough for CLKS_PER_BIT up to 1023; guard counter SHALL be wide enough for CLEAR_GUARD up to 65535.

Reset
REQ-023 Reset asserted SHALL immediately force out_uart_tx=1, out_cmd_ready=0, out_cmd_error=0, state IDLE, shadow cursor (0,0) invalid, all counters 0, aborting any frame in progress.
REQ-024 out_cmd_ready SHALL go high the first clock after reset deassertion.

Configuration
REQ-025 Macro EL_CMD_TX_CURSOR_SKIP_EN defined: op 01 SHALL omit the column byte when the shadow is valid and shadow col equals in_cmd_col, and omit the row byte when valid and shadow row equals in_cmd_row.
REQ-026 Macro undefined: op 01 SHALL always emit all three bytes; the shadow cursor is still maintained but unused.

Verification (bench uses CLKS_PER_BIT=4, CLEAR_GUARD=16)
REQ-027 op 00 char 0x41 -> line: 4 cycles low, bits 1,0,0,0,0,0,1,0, 4 cycles high; ready back 40 cycles after start.
REQ-028 op 01 col 5 row 3 char 0x42 -> bytes 0x85, 0xC3, 0x42 contiguous, 120 cycles; ready high the cycle after.
REQ-029 op 10 -> byte 0xFF, then ready low 16 further cycles with line high; valid held high during that time is not accepted.
REQ-030 op 01 col 40 row 0 -> no start bit, out_cmd_error single pulse, ready high next cycle; op 00 char 0x0D gives the same.
REQ-031 With EL_CMD_TX_CURSOR_SKIP_EN: op 01 (5,3,'B') then op 01 (6,3,'C') -> second command emits only 0x43; without the macro it emits 0x86, 0xC3, 0x43.
REQ-032 Reset asserted mid-data-bit of byte 0xC3 -> line high same cycle; after release, op 00 0x41 emits a clean single frame.
